// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer: state encoding,
//   PC width shared with the sibling `pc` block, and enable/disable levels.
//   No ports; imported by fetch_ctrl and fetch_ctrl_if.
package fetch_ctrl_pkg;

  // Width of the program counter; fetch_ctrl's ADDR_WIDTH must match it.
  localparam int PC_ADDR_WIDTH    = 16;
  localparam int FETCH_DATA_WIDTH = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_FETCH  = 2'd1,
    FETCH_HOLD   = 2'd2,
    FETCH_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
//   Bundles the instruction-memory request/ack bus and the decode-side
//   valid/ready instruction handshake.
//   master: the fetch sequencer (drives imem_req/imem_addr and ir_*).
//   slave : the environment (memory returns imem_ack/imem_data, decode
//           drives ir_ready).
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_data;

  logic                  ir_valid;
  logic [DATA_WIDTH-1:0] ir_data;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_ready;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    input  imem_ack, imem_data, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
    output imem_ack, imem_data, ir_ready
  );

endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch sequencer. Issues one instruction-memory fetch at a
//   time at the current PC, advances the PC on each accepted fetch, applies
//   branch redirects from execute and hands fetched words to decode.
//
//   Ports:
//     clk            system clock, rising edge
//     reset          asynchronous, active-low reset
//     run            fetch enable (level)
//     halt           stop request, sticky until reset
//     redirect       taken branch/jump pulse from execute
//     redirect_addr  redirect target
//     pc_addr        current PC from the sibling pc block
//     pc_en/pc_jmp   pc control (combinational)
//     pc_target      pc load value (always redirect_addr)
//     busy           state is FETCH or HOLD (registered)
//     bus            memory request bus + decode handshake (master side)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_en,
  output logic                  pc_jmp,
  output logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  busy,
  fetch_ctrl_if.master          bus
);

  fetch_state_e          state_reg;
  logic                  discard_reg;
  logic                  halt_pending_reg;
  logic [ADDR_WIDTH-1:0] fetch_addr_reg;
  logic                  imem_req_reg;
  logic                  ir_valid_reg;
  logic [DATA_WIDTH-1:0] ir_data_reg;
  logic [ADDR_WIDTH-1:0] ir_pc_reg;
  logic                  busy_reg;

  logic                  halt_eff;
  logic                  redirect_live;
  logic                  accept_fetch;
  logic [ADDR_WIDTH-1:0] next_pc;

  // A halt seen while a fetch is outstanding must survive until the ack,
  // so the request is latched rather than sampled only at the ack.
  assign halt_eff = halt | halt_pending_reg;

  // Redirects reach the PC in the same cycle unless the block is halted.
  assign redirect_live = redirect && (state_reg != FETCH_HALTED);

  // Only a clean ack (no pending discard, no redirect, no halt) advances
  // the PC by one; a coincident redirect turns the update into a pure jump.
  assign accept_fetch = (state_reg == FETCH_FETCH) && bus.imem_ack &&
                        !discard_reg && !redirect && !halt_eff;

  assign pc_en     = (redirect_live || accept_fetch) ? ENABLE : DISABLE;
  assign pc_jmp    = redirect_live ? ENABLE : DISABLE;
  assign pc_target = redirect_addr;

  // Value the PC will hold after this edge; loaded on every FETCH entry.
  assign next_pc = redirect ? redirect_addr
                 : (pc_en ? pc_addr + 1'b1 : pc_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= FETCH_IDLE;
      discard_reg      <= 1'b0;
      halt_pending_reg <= 1'b0;
      fetch_addr_reg   <= '0;
      imem_req_reg     <= 1'b0;
      ir_valid_reg     <= 1'b0;
      ir_data_reg      <= '0;
      ir_pc_reg        <= '0;
      busy_reg         <= 1'b0;
    end else begin
      if (halt && (state_reg != FETCH_HALTED)) begin
        halt_pending_reg <= 1'b1;
      end

      case (state_reg)
        FETCH_IDLE: begin
          if (halt_eff) begin
            state_reg <= FETCH_HALTED;
          end else if (run) begin
            state_reg      <= FETCH_FETCH;
            imem_req_reg   <= ENABLE;
            fetch_addr_reg <= next_pc;
            busy_reg       <= 1'b1;
          end
        end

        FETCH_FETCH: begin
          if (bus.imem_ack) begin
            discard_reg <= 1'b0;
            if (halt_eff) begin
              state_reg    <= FETCH_HALTED;
              imem_req_reg <= DISABLE;
              busy_reg     <= 1'b0;
            end else if (discard_reg || redirect) begin
              // Stale word: drop it and re-request at the new PC. The
              // request line stays high across the re-entry.
              fetch_addr_reg <= next_pc;
            end else begin
              state_reg    <= FETCH_HOLD;
              imem_req_reg <= DISABLE;
              ir_valid_reg <= 1'b1;
              ir_data_reg  <= bus.imem_data;
              ir_pc_reg    <= fetch_addr_reg;
            end
          end else if (redirect) begin
            // The outstanding request cannot be withdrawn; mark its data
            // as stale so it is dropped when it finally returns.
            discard_reg <= 1'b1;
          end
        end

        FETCH_HOLD: begin
          if (halt_eff) begin
            state_reg    <= FETCH_HALTED;
            ir_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end else if (redirect) begin
            state_reg      <= FETCH_FETCH;
            ir_valid_reg   <= 1'b0;
            imem_req_reg   <= ENABLE;
            fetch_addr_reg <= next_pc;
          end else if (bus.ir_ready) begin
            ir_valid_reg <= 1'b0;
            if (run) begin
              state_reg      <= FETCH_FETCH;
              imem_req_reg   <= ENABLE;
              fetch_addr_reg <= next_pc;
            end else begin
              state_reg <= FETCH_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end

        FETCH_HALTED: begin
          // Terminal until reset.
        end

        default: begin
          state_reg <= FETCH_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_reg;
  assign bus.imem_addr = fetch_addr_reg;
  assign bus.ir_valid  = ir_valid_reg;
  assign bus.ir_data   = ir_data_reg;
  assign bus.ir_pc     = ir_pc_reg;
  assign busy          = busy_reg;

endmodule
